// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: writable instruction memory, program counter and
// commit strobe for the downstream decoder. Runs a loaded program either
// free-running (one commit per cycle) or one instruction per step_btn rise,
// then parks in HALTED until the next start or reset.
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter int INSTR_W    = 12,
    parameter int IMEM_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    input  logic               run_mode,
    input  logic               step_btn,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               exec_en,
    output logic               halted,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    // Largest program that fits in memory; longer requests are clamped to it.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IMEM_DEPTH);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_nxt_s;
    logic [ADDR_W:0]    len_r;
    logic [ADDR_W:0]    len_nxt_s;
    logic [ADDR_W:0]    len_clamp_s;
    logic               step_prev_r;
    logic               step_rise_s;
    logic               exec_en_s;
    logic               last_s;
    logic               prog_ok_s;
    logic [INSTR_W-1:0] imem_r [IMEM_DEPTH];

    assign step_rise_s = step_btn & ~step_prev_r;
    assign prog_ok_s   = (state_r == ST_IDLE) || (state_r == ST_HALTED);
    assign len_clamp_s = (prog_len > DEPTH_C) ? DEPTH_C : prog_len;
    // len_r is at least one whenever this is consulted (RUN/STEP only).
    assign last_s      = ({1'b0, pc_r} == (len_r - (ADDR_W+1)'(1)));

    // Commit strobe: every cycle in RUN, only on a button rise in STEP.
    // Suppressed while reset is asserted so an aborted run never half-commits.
    always_comb begin
        exec_en_s = 1'b0;
        if (reset) begin
            exec_en_s = 1'b0;
        end else begin
            exec_en_s = (state_r == ST_RUN) || ((state_r == ST_STEP) && step_rise_s);
        end
    end

    // Next-state, PC and length sequencing.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        len_nxt_s   = len_r;
        case (state_r)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    len_nxt_s = len_clamp_s;
                    pc_nxt_s  = '0;
                    if (len_clamp_s == '0) begin
                        state_nxt_s = ST_HALTED;
                    end else if (run_mode) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_STEP;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN, ST_STEP: begin
                if (exec_en_s) begin
                    if (last_s) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        pc_nxt_s = pc_r + ADDR_W'(1);
                    end
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = '0;
                len_nxt_s   = '0;
            end
        endcase
    end

    // Control registers; the button history is tracked in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pc_r        <= '0;
            len_r       <= '0;
            step_prev_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            len_r       <= len_nxt_s;
            step_prev_r <= step_btn;
        end
    end

    // Instruction memory: loadable only while no program is executing, and
    // deliberately not cleared by reset so the program survives it.
    always_ff @(posedge clk) begin
        if (prog_we && !reset && prog_ok_s) begin
            imem_r[prog_addr] <= prog_data;
        end
    end

    assign instr   = imem_r[pc_r];
    assign pc      = pc_r;
    assign exec_en = exec_en_s;
    assign halted  = (state_r == ST_HALTED);
    assign state   = state_r;

endmodule
